// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port instruction/data memory between the fetch stage and
// the memory stage of a 5-stage RISC-V pipeline. Requests are serialised onto
// a req/ack memory port, each completion is returned with a one-cycle valid
// pulse, and per-stage stall signals are raised for the hazard logic. A
// watchdog aborts memory transactions that never acknowledge.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width
//   TIMEOUT  max cycles mem_req_o may wait for mem_ack_i (>= 1)
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   if_req_i/if_addr_i          fetch request (may be withdrawn = flush)
//   if_rdata_o/if_valid_o       fetch completion
//   d_req_i/d_we_i/d_addr_i/
//   d_wdata_i                   load/store request (never withdrawn)
//   d_rdata_o/d_valid_o         data completion
//   stall_if_o/stall_mem_o      combinational stall requests
//   mem_req_o/mem_we_o/
//   mem_addr_o/mem_wdata_o      memory request side
//   mem_ack_i/mem_rdata_i       memory completion side
//   err_o                       sticky timeout flag
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,

  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_valid_o,

  output logic              stall_if_o,
  output logic              stall_mem_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,

  output logic              err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Count value during the last permitted wait cycle: the counter holds 0 in
  // the first BUSY cycle, so TIMEOUT cycles without ack end at TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   cap_q,       cap_d;       // data captured at ack/timeout
  logic                owner_d_q,   owner_d_d;   // 1 = data stage owns the port
  logic                drop_q,      drop_d;      // fetch flushed during BUSY_I
  logic                err_q,       err_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;

  logic                if_valid;
  logic                d_valid;

  // Valid pulses are decoded from the RESP state. A fetch withdrawn at any
  // point of its transaction (flag for BUSY_I, live request for RESP) gets
  // no pulse.
  assign if_valid = (state_q == RESP) && !owner_d_q && !drop_q && if_req_i;
  assign d_valid  = (state_q == RESP) &&  owner_d_q;

  // During the valid cycle the captured word is forwarded directly; the
  // per-port holding register is updated at the end of that cycle so a
  // discarded fetch never disturbs the previously delivered value.
  assign if_rdata_o  = if_valid ? cap_q : if_rdata_q;
  assign d_rdata_o   = (d_valid && !mem_we_q) ? cap_q : d_rdata_q;
  assign if_valid_o  = if_valid;
  assign d_valid_o   = d_valid;

  assign stall_if_o  = if_req_i & ~if_valid;
  assign stall_mem_o = d_req_i  & ~d_valid;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves a
    // variable unassigned, which would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cap_d       = cap_q;
    owner_d_d   = owner_d_q;
    drop_d      = drop_q;
    err_d       = err_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        // Data has fixed priority: it belongs to the older instruction.
        if (d_req_i) begin
          state_d     = BUSY_D;
          owner_d_d   = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          cnt_d       = '0;
          drop_d      = 1'b0;
        end else if (if_req_i) begin
          state_d     = BUSY_I;
          owner_d_d   = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          cnt_d       = '0;
          drop_d      = 1'b0;
        end
      end

      BUSY_I, BUSY_D: begin
        if (state_q == BUSY_I && !if_req_i) begin
          drop_d = 1'b1;
        end
        // An ack in the limit cycle wins over the watchdog.
        if (mem_ack_i) begin
          cap_d     = mem_rdata_i;
          mem_req_d = 1'b0;
          state_d   = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cap_d     = '0;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
        if (if_valid) begin
          if_rdata_d = cap_q;
        end
        if (d_valid && !mem_we_q) begin
          d_rdata_d = cap_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order; the reset
  // branch sits inside the clocked block, making it synchronous.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cap_q       <= '0;
      owner_d_q   <= 1'b0;
      drop_q      <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cap_q       <= cap_d;
      owner_d_q   <= owner_d_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A small memory responder acks after a
// programmable number of wait states (or never); read data is a fixed
// function of the address so expected words are known constants.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_valid_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [31:0] d_rdata_o;
  logic        d_valid_o;
  logic        stall_if_o;
  logic        stall_mem_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  int ack_delay = 0;
  bit never_ack = 1'b0;
  int wait_cnt  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_valid_o  (if_valid_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_rdata_o   (d_rdata_o),
    .d_valid_o   (d_valid_o),
    .stall_if_o  (stall_if_o),
    .stall_mem_o (stall_mem_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .err_o       (err_o)
  );

  // Memory responder: wait_cnt counts request cycles already spent without ack.
  always @(posedge clk) begin
    if (!mem_req_o || mem_ack_i) wait_cnt <= 0;
    else                         wait_cnt <= wait_cnt + 1;
  end

  assign mem_ack_i   = mem_req_o && !never_ack && (wait_cnt == ack_delay);
  assign mem_rdata_i = (mem_addr_o == 32'h0000_0010) ? 32'h0050_0093
                                                     : (mem_addr_o ^ 32'hA5A5_0000);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Start of next cycle (drive point) and middle of current cycle (sample point).
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int n;
    int req_cycles;

    rst = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;

    // ---------------- reset values
    edge_step(); edge_step(); mid();
    check("rst_mem_req",   {31'd0, mem_req_o},  32'd0);
    check("rst_mem_we",    {31'd0, mem_we_o},   32'd0);
    check("rst_mem_addr",  mem_addr_o,          32'd0);
    check("rst_mem_wdata", mem_wdata_o,         32'd0);
    check("rst_if_valid",  {31'd0, if_valid_o}, 32'd0);
    check("rst_d_valid",   {31'd0, d_valid_o},  32'd0);
    check("rst_if_rdata",  if_rdata_o,          32'd0);
    check("rst_d_rdata",   d_rdata_o,           32'd0);
    check("rst_err",       {31'd0, err_o},      32'd0);
    edge_step(); rst = 1'b1;

    // ---------------- single fetch, zero wait
    edge_step(); if_req_i = 1'b1; if_addr_i = 32'h10; ack_delay = 0;   // cycle 0
    mid();
    check("f0_stall_c0",   {31'd0, stall_if_o}, 32'd1);
    check("f0_req_c0",     {31'd0, mem_req_o},  32'd0);
    edge_step(); mid();                                                // cycle 1
    check("f0_req_c1",     {31'd0, mem_req_o},  32'd1);
    check("f0_addr_c1",    mem_addr_o,          32'h10);
    check("f0_we_c1",      {31'd0, mem_we_o},   32'd0);
    check("f0_stall_c1",   {31'd0, stall_if_o}, 32'd1);
    edge_step(); mid();                                                // cycle 2
    check("f0_valid_c2",   {31'd0, if_valid_o}, 32'd1);
    check("f0_rdata_c2",   if_rdata_o,          32'h0050_0093);
    check("f0_req_c2",     {31'd0, mem_req_o},  32'd0);
    check("f0_stall_c2",   {31'd0, stall_if_o}, 32'd0);
    edge_step(); if_req_i = 1'b0;                                      // cycle 3
    mid();
    check("f0_valid_c3",   {31'd0, if_valid_o}, 32'd0);
    check("f0_rdata_hold", if_rdata_o,          32'h0050_0093);

    // ---------------- contention: data first, then fetch
    edge_step();                                                       // cycle 0
    if_req_i = 1'b1; if_addr_i = 32'h14;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h100; ack_delay = 2;
    mid();
    check("ct_stall_if_c0",  {31'd0, stall_if_o},  32'd1);
    check("ct_stall_mem_c0", {31'd0, stall_mem_o}, 32'd1);
    edge_step(); mid();                                                // cycle 1
    check("ct_req_c1",     {31'd0, mem_req_o}, 32'd1);
    check("ct_addr_c1",    mem_addr_o,         32'h100);
    edge_step(); edge_step(); mid();                                   // cycle 3
    check("ct_req_c3",     {31'd0, mem_req_o}, 32'd1);
    check("ct_dvalid_c3",  {31'd0, d_valid_o}, 32'd0);
    edge_step(); mid();                                                // cycle 4
    check("ct_dvalid_c4",  {31'd0, d_valid_o},  32'd1);
    check("ct_drdata_c4",  d_rdata_o,           32'hA5A5_0100);
    check("ct_ivalid_c4",  {31'd0, if_valid_o}, 32'd0);
    check("ct_stall_if_c4",{31'd0, stall_if_o}, 32'd1);
    check("ct_stall_mem_c4",{31'd0, stall_mem_o}, 32'd0);
    edge_step(); d_req_i = 1'b0;                                       // cycle 5
    mid();
    check("ct_req_c5",     {31'd0, mem_req_o}, 32'd0);
    edge_step(); mid();                                                // cycle 6
    check("ct_req_c6",     {31'd0, mem_req_o}, 32'd1);
    check("ct_addr_c6",    mem_addr_o,         32'h14);
    edge_step(); edge_step(); mid();                                   // cycle 8
    check("ct_ivalid_c8",  {31'd0, if_valid_o}, 32'd0);
    edge_step(); mid();                                                // cycle 9
    check("ct_ivalid_c9",  {31'd0, if_valid_o}, 32'd1);
    check("ct_irdata_c9",  if_rdata_o,          32'hA5A5_0014);
    edge_step(); if_req_i = 1'b0;

    // ---------------- store
    edge_step();                                                       // cycle 0
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h20; d_wdata_i = 32'hDEAD_BEEF;
    ack_delay = 1;
    edge_step(); mid();                                                // cycle 1
    check("st_we_c1",      {31'd0, mem_we_o}, 32'd1);
    check("st_wdata_c1",   mem_wdata_o,       32'hDEAD_BEEF);
    check("st_addr_c1",    mem_addr_o,        32'h20);
    edge_step(); mid();                                                // cycle 2 (ack)
    check("st_req_c2",     {31'd0, mem_req_o}, 32'd1);
    check("st_we_c2",      {31'd0, mem_we_o},  32'd1);
    check("st_wdata_c2",   mem_wdata_o,        32'hDEAD_BEEF);
    edge_step(); mid();                                                // cycle 3
    check("st_dvalid_c3",  {31'd0, d_valid_o}, 32'd1);
    check("st_drdata_c3",  d_rdata_o,          32'hA5A5_0100);
    edge_step(); d_req_i = 1'b0; d_we_i = 1'b0;
    mid();
    check("st_drdata_after", d_rdata_o, 32'hA5A5_0100);

    // ---------------- fetch flush (withdrawn in BUSY_I, re-raised before RESP)
    edge_step(); if_req_i = 1'b1; if_addr_i = 32'h30; ack_delay = 1;   // cycle 0
    edge_step(); if_req_i = 1'b0;                                      // cycle 1
    mid();
    check("fl_req_c1",     {31'd0, mem_req_o}, 32'd1);
    edge_step(); if_req_i = 1'b1;                                      // cycle 2 (ack)
    mid();
    check("fl_req_c2",     {31'd0, mem_req_o}, 32'd1);
    check("fl_addr_c2",    mem_addr_o,         32'h30);
    edge_step(); mid();                                                // cycle 3
    check("fl_ivalid_c3",  {31'd0, if_valid_o}, 32'd0);
    check("fl_irdata_c3",  if_rdata_o,          32'hA5A5_0014);
    check("fl_req_c3",     {31'd0, mem_req_o},  32'd0);
    edge_step(); if_req_i = 1'b0;                                      // cycle 4
    mid();
    check("fl_irdata_c4",  if_rdata_o,          32'hA5A5_0014);

    // ---------------- ack in the limit cycle: ack wins, no error
    edge_step(); d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h48; ack_delay = 14;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      edge_step(); mid();
      if (d_valid_o) begin n = i; break; end
    end
    check("lim_cycles",    n,                  32'd16);
    check("lim_drdata",    d_rdata_o,          32'hA5A5_0048);
    check("lim_err",       {31'd0, err_o},     32'd0);
    edge_step(); d_req_i = 1'b0;

    // ---------------- timeout
    edge_step(); d_req_i = 1'b1; d_addr_i = 32'h44; never_ack = 1'b1;  // cycle 0
    req_cycles = 0;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      edge_step(); mid();
      if (mem_req_o) req_cycles++;
      if (d_valid_o) begin n = i; break; end
    end
    check("to_req_cycles", req_cycles,         32'd15);
    check("to_valid_cyc",  n,                  32'd16);
    check("to_drdata",     d_rdata_o,          32'd0);
    check("to_err",        {31'd0, err_o},     32'd1);
    edge_step(); d_req_i = 1'b0; never_ack = 1'b0;
    mid();
    check("to_err_hold",   {31'd0, err_o},     32'd1);

    // ---------------- good fetch after timeout: err stays sticky
    edge_step(); if_req_i = 1'b1; if_addr_i = 32'h10; ack_delay = 0;
    edge_step(); edge_step(); mid();
    check("pt_ivalid",     {31'd0, if_valid_o}, 32'd1);
    check("pt_irdata",     if_rdata_o,          32'h0050_0093);
    check("pt_err",        {31'd0, err_o},      32'd1);
    edge_step(); if_req_i = 1'b0;

    // ---------------- reset during BUSY_D
    edge_step(); d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200; ack_delay = 3;
    edge_step(); mid();                                                // cycle 1
    check("rm_req_c1",     {31'd0, mem_req_o}, 32'd1);
    edge_step(); rst = 1'b0;                                           // cycle 2
    edge_step(); rst = 1'b1;                                           // cycle 3
    mid();
    check("rm_req",        {31'd0, mem_req_o},  32'd0);
    check("rm_addr",       mem_addr_o,          32'd0);
    check("rm_err",        {31'd0, err_o},      32'd0);
    check("rm_dvalid",     {31'd0, d_valid_o},  32'd0);
    check("rm_drdata",     d_rdata_o,           32'd0);
    check("rm_irdata",     if_rdata_o,          32'd0);
    check("rm_stall_mem",  {31'd0, stall_mem_o}, 32'd1);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      edge_step(); mid();
      if (d_valid_o) begin n = i; break; end
    end
    check("rm_valid_cyc",  n,                  32'd5);
    check("rm_drdata_new", d_rdata_o,          32'hA5A5_0200);
    edge_step(); d_req_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
